// File: rtl/pk_hasti.sv
// pk_hasti: shared HASTI (AHB-Lite) bus encodings used by the vscale bus
// fabric -- transfer types on htrans and the single-bit hresp codes.
package pk_hasti;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

endpackage

// File: rtl/pk_hasti_map.sv
// pk_hasti_map: system address map for the HASTI interconnect.
//   slot 0 : ROM  0x0000_0000 .. 0x0000_0FFF
//   slot 1 : RAM  0x1000_0000 .. 0x1000_FFFF
//   slot 2 : I/O  0x2000_0000 .. 0x2000_0FFF
// Also holds the default-slave state type.
package pk_hasti_map;

  localparam int N_SLAVES = 3;

  // Packed [slot][32]; slot 0 is the rightmost element.
  localparam logic [N_SLAVES-1:0][31:0] SLAVE_BASE = {
    32'h2000_0000,
    32'h1000_0000,
    32'h0000_0000
  };

  localparam logic [N_SLAVES-1:0][31:0] SLAVE_MASK = {
    32'hFFFF_F000,
    32'hFFFF_0000,
    32'hFFFF_F000
  };

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dflt_state_e;

endpackage

// File: rtl/hasti_default_slave.sv
// hasti_default_slave: responder for addresses that hit no mapped slave.
// Active transfers get the AHB two-cycle ERROR response; IDLE/BUSY get a
// zero-wait OKAY. Read data is always zero.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   D_IDLE | no error in progress; ready=1, OKAY
//   D_ERR1 | first error cycle; ready=0, ERROR (master may cancel)
//   D_ERR2 | second error cycle; ready=1, ERROR
//
// Ports:
//   hclk, hreset      bus clock, synchronous active-high reset
//   hsel              address phase targets the default slave
//   htrans            master transfer type
//   hready            bus-wide ready (address phase is valid when 1)
//   hreadyout, hresp  response to the data-phase mux
//   hrdata            read data (constant zero)
module hasti_default_slave
  import pk_hasti::*;
  import pk_hasti_map::*;
(
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  dflt_state_e state_q, state_d;
  logic        err_req;

  // A new error is started only by an accepted active transfer.
  assign err_req = hsel && hready && ((htrans == NONSEQ) || (htrans == SEQ));

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= D_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = OKAY;
    unique case (state_q)
      D_IDLE: begin
        if (err_req) state_d = D_ERR1;
      end
      D_ERR1: begin
        hreadyout = 1'b0;
        hresp     = ERROR;
        state_d   = D_ERR2;
      end
      D_ERR2: begin
        hresp   = ERROR;
        state_d = err_req ? D_ERR1 : D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  assign hrdata = 32'h0;

endmodule

// File: rtl/hasti_interconnect.sv
// hasti_interconnect: single-master, N-slave HASTI interconnect.
// Decodes the address phase into a one-hot s_hsel, registers the chosen
// slave index into the data phase (dsel) and muxes the slave responses
// back to the master. Unmapped addresses go to hasti_default_slave.
//
// Ports:
//   hclk, hreset   bus clock, synchronous active-high reset
//   m_haddr        master address
//   m_htrans       master transfer type
//   m_hrdata       muxed read data
//   m_hready       muxed ready, also the bus-wide hready for all slaves
//   m_hresp        muxed response
//   s_hsel         one-hot address-phase slave select
//   s_hrdata       per-slave read data
//   s_hreadyout    per-slave ready
//   s_hresp        per-slave response
module hasti_interconnect
  import pk_hasti::*;
#(
  parameter int                          N_SLAVES = pk_hasti_map::N_SLAVES,
  parameter logic [N_SLAVES-1:0][31:0]   BASE     = pk_hasti_map::SLAVE_BASE,
  parameter logic [N_SLAVES-1:0][31:0]   MASK     = pk_hasti_map::SLAVE_MASK
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [31:0]                  m_haddr,
  input  logic [1:0]                   m_htrans,
  output logic [31:0]                  m_hrdata,
  output logic                         m_hready,
  output logic                         m_hresp,
  output logic [N_SLAVES-1:0]          s_hsel,
  input  logic [N_SLAVES-1:0][31:0]    s_hrdata,
  input  logic [N_SLAVES-1:0]          s_hreadyout,
  input  logic [N_SLAVES-1:0]          s_hresp
);

  localparam int             DW       = $clog2(N_SLAVES + 1);
  localparam logic [DW-1:0]  DSEL_DEF = DW'(N_SLAVES);

  logic [DW-1:0] dec_idx;
  logic [DW-1:0] dsel_q, dsel_d;
  logic          unmapped;

  logic          def_hreadyout;
  logic          def_hresp;
  logic [31:0]   def_hrdata;

  // Scan from the top down so the lowest matching index ends up winning.
  always_comb begin
    dec_idx = DSEL_DEF;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_haddr & MASK[i]) == BASE[i]) dec_idx = DW'(i);
    end
  end

  assign unmapped = (dec_idx == DSEL_DEF);

  always_comb begin
    s_hsel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_hsel[i] = (dec_idx == DW'(i));
    end
  end

  // Data-phase owner advances only when the current data phase completes.
  assign dsel_d = m_hready ? dec_idx : dsel_q;

  always_ff @(posedge hclk) begin
    if (hreset) dsel_q <= DSEL_DEF;
    else        dsel_q <= dsel_d;
  end

  always_comb begin
    m_hrdata = def_hrdata;
    m_hready = def_hreadyout;
    m_hresp  = def_hresp;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dsel_q == DW'(i)) begin
        m_hrdata = s_hrdata[i];
        m_hready = s_hreadyout[i];
        m_hresp  = s_hresp[i];
      end
    end
  end

  hasti_default_slave u_default_slave (
    .hclk      (hclk),
    .hreset    (hreset),
    .hsel      (unmapped),
    .htrans    (m_htrans),
    .hready    (m_hready),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp),
    .hrdata    (def_hrdata)
  );

endmodule
